neopixel_cmd_engine: RTL and testbench

NEOPIXEL_CMD_ENGINE -- requirements
Module: neopixel_cmd_engine

---
 rtl/neopixel_cmd_engine.sv | 179 +++++++++++++++++
 tb/tb_neopixel_cmd_engine.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/neopixel_cmd_engine.sv
// Command engine for a NeoPixel strip: FIFO-buffered SET_PTR/WRITE/FILL commands become pixel writes.
// Latency: a WRITE strobed into an empty, idle engine appears as ctrl_write_en three cycles later.
// Backpressure: waits while ctrl_ready is low; cmd_full reflects FIFO occupancy, drops set sticky overflow.
module neopixel_cmd_engine #(
    parameter int C_PIXELS     = 12,
    parameter int C_FIFO_DEPTH = 4
) (
    input  logic        ctrl_clock,
    input  logic        ctrl_reset_n,
    input  logic [31:0] cmd_data,
    input  logic        cmd_write_en,
    output logic        cmd_full,
    output logic        overflow,
    output logic        busy,
    output logic        ctrl_write_en,
    output logic [31:0] ctrl_address,
    output logic [31:0] ctrl_write_data,
    input  logic        ctrl_ready
);

    localparam int                LP_AW    = (C_FIFO_DEPTH > 1) ? $clog2(C_FIFO_DEPTH) : 1;
    localparam int                LP_CW    = LP_AW + 1;
    localparam logic [LP_CW-1:0]  LP_DEPTH = LP_CW'(C_FIFO_DEPTH);
    localparam logic [LP_CW-1:0]  LP_ONE   = LP_CW'(1);
    localparam logic [8:0]        LP_NPIX  = 9'(C_PIXELS);
    localparam logic [7:0]        LP_LAST  = 8'(C_PIXELS - 1);

    localparam logic [1:0] OP_SET_PTR = 2'b00;
    localparam logic [1:0] OP_WRITE   = 2'b01;
    localparam logic [1:0] OP_FILL    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_FILL = 2'd2
    } state_t;

    // FIFO entries keep only the opcode and the 24 payload bits; [29:24] carry nothing.
    logic [25:0]       r_mem [C_FIFO_DEPTH];
    logic [LP_AW-1:0]  r_wr_ptr;
    logic [LP_AW-1:0]  r_rd_ptr;
    logic [LP_CW-1:0]  r_count;
    logic              r_overflow;

    state_t            r_state;
    logic [1:0]        r_op;
    logic [23:0]       r_arg;
    logic [7:0]        r_ptr;
    logic [7:0]        r_fill_cnt;
    logic              r_wen;
    logic [7:0]        r_addr;
    logic [23:0]       r_data;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_unused;

    assign w_full   = (r_count == LP_DEPTH);
    assign w_empty  = (r_count == '0);
    assign w_push   = cmd_write_en && !w_full;
    assign w_pop    = (r_state == ST_IDLE) && !w_empty;
    assign w_unused = &{1'b0, cmd_data[29:24]};

    assign cmd_full        = w_full;
    assign overflow        = r_overflow;
    assign busy            = !w_empty || (r_state != ST_IDLE);
    assign ctrl_write_en   = r_wen;
    assign ctrl_address    = {24'd0, r_addr};
    assign ctrl_write_data = {8'h00, r_data};

    // FIFO storage: written on accepted pushes only, so no reset is needed.
    always_ff @(posedge ctrl_clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_data[31:30], cmd_data[23:0]};
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge ctrl_clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + LP_ONE;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - LP_ONE;
            end
        end
    end

    // Sticky drop flag: a strobe against a full FIFO is lost even if a pop frees a slot this cycle.
    always_ff @(posedge ctrl_clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_overflow <= 1'b0;
        end else if (cmd_write_en && w_full) begin
            r_overflow <= 1'b1;
        end
    end

    // Command FSM with registered pixel-write outputs; address/data hold between strobes.
    always_ff @(posedge ctrl_clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_state    <= ST_IDLE;
            r_op       <= 2'b00;
            r_arg      <= '0;
            r_ptr      <= '0;
            r_fill_cnt <= '0;
            r_wen      <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
        end else begin
            r_wen <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        {r_op, r_arg} <= r_mem[r_rd_ptr];
                        r_state       <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (r_op)
                        OP_SET_PTR: begin
                            // Out-of-range indices park the pointer at the first pixel.
                            if ({1'b0, r_arg[7:0]} >= LP_NPIX) begin
                                r_ptr <= '0;
                            end else begin
                                r_ptr <= r_arg[7:0];
                            end
                            r_state <= ST_IDLE;
                        end
                        OP_WRITE: begin
                            if (ctrl_ready) begin
                                r_wen   <= 1'b1;
                                r_addr  <= r_ptr;
                                r_data  <= r_arg;
                                r_ptr   <= (r_ptr == LP_LAST) ? 8'd0 : r_ptr + 8'd1;
                                r_state <= ST_IDLE;
                            end
                        end
                        OP_FILL: begin
                            r_fill_cnt <= '0;
                            r_state    <= ST_FILL;
                        end
                        default: begin
                            r_state <= ST_IDLE;
                        end
                    endcase
                end
                ST_FILL: begin
                    if (ctrl_ready) begin
                        r_wen  <= 1'b1;
                        r_addr <= r_fill_cnt;
                        r_data <= r_arg;
                        if (r_fill_cnt == LP_LAST) begin
                            r_fill_cnt <= '0;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_fill_cnt <= r_fill_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neopixel_cmd_engine.sv
// Directed bench for neopixel_cmd_engine: reset, latency, pointer wrap, fill backpressure,
// FIFO overflow and reset during a fill, all against hand-computed expectations.
module tb_neopixel_cmd_engine;

    logic        ctrl_clock   = 1'b0;
    logic        ctrl_reset_n = 1'b1;
    logic [31:0] cmd_data     = '0;
    logic        cmd_write_en = 1'b0;
    logic        cmd_full;
    logic        overflow;
    logic        busy;
    logic        ctrl_write_en;
    logic [31:0] ctrl_address;
    logic [31:0] ctrl_write_data;
    logic        ctrl_ready   = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    logic        prev_ready  = 1'b0;
    int          bad_strobes = 0;

    neopixel_cmd_engine #(
        .C_PIXELS     (12),
        .C_FIFO_DEPTH (4)
    ) dut (
        .ctrl_clock      (ctrl_clock),
        .ctrl_reset_n    (ctrl_reset_n),
        .cmd_data        (cmd_data),
        .cmd_write_en    (cmd_write_en),
        .cmd_full        (cmd_full),
        .overflow        (overflow),
        .busy            (busy),
        .ctrl_write_en   (ctrl_write_en),
        .ctrl_address    (ctrl_address),
        .ctrl_write_data (ctrl_write_data),
        .ctrl_ready      (ctrl_ready)
    );

    always #5 ctrl_clock = ~ctrl_clock;

    // Record every strobe; a strobe is legal only if ctrl_ready was high the cycle before.
    always @(negedge ctrl_clock) begin
        if (ctrl_write_en === 1'b1) begin
            q_addr.push_back(ctrl_address);
            q_data.push_back(ctrl_write_data);
            if (!prev_ready) bad_strobes++;
        end
        prev_ready = ctrl_ready;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ctrl_clock);
        #1;
    endtask

    task automatic send(input logic [31:0] c);
        cmd_data     = c;
        cmd_write_en = 1'b1;
        tick();
        cmd_write_en = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        chk("idle", 32'(busy), 32'd0);
        tick();
        tick();
    endtask

    task automatic clear_log();
        q_addr.delete();
        q_data.delete();
    endtask

    function automatic logic [31:0] log_addr(input int i);
        return (i < q_addr.size()) ? q_addr[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] log_data(input int i);
        return (i < q_data.size()) ? q_data[i] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int n;

        // Reset state
        #1 ctrl_reset_n = 1'b0;
        tick();
        tick();
        chk("rst_full",  32'(cmd_full),      32'd0);
        chk("rst_ovf",   32'(overflow),      32'd0);
        chk("rst_busy",  32'(busy),          32'd0);
        chk("rst_wen",   32'(ctrl_write_en), 32'd0);
        chk("rst_addr",  ctrl_address,       32'd0);
        chk("rst_data",  ctrl_write_data,    32'd0);
        ctrl_reset_n = 1'b1;
        tick();

        // Single write with exact latency: strobe in cycle N, strobe out in cycle N+3
        ctrl_ready = 1'b1;
        send(32'h0000_0005);
        wait_idle(20);
        clear_log();
        cmd_data     = 32'h40FF_0000;
        cmd_write_en = 1'b1;
        tick();
        cmd_write_en = 1'b0;
        chk("lat_n1_wen", 32'(ctrl_write_en), 32'd0);
        tick();
        chk("lat_n2_wen", 32'(ctrl_write_en), 32'd0);
        tick();
        chk("lat_n3_wen",  32'(ctrl_write_en), 32'd1);
        chk("lat_n3_addr", ctrl_address,       32'd5);
        chk("lat_n3_data", ctrl_write_data,    32'h00FF_0000);
        tick();
        chk("one_cycle_wen", 32'(ctrl_write_en), 32'd0);
        chk("hold_addr",     ctrl_address,       32'd5);
        chk("hold_data",     ctrl_write_data,    32'h00FF_0000);
        wait_idle(20);
        chk("single_count", 32'(q_addr.size()), 32'd1);

        // Pointer wrap, out-of-range SET_PTR, reserved op
        clear_log();
        send(32'h0000_000B);
        send(32'h40AA_AAAA);
        send(32'h40BB_BBBB);
        wait_idle(50);
        chk("wrap_count",  32'(q_addr.size()), 32'd2);
        chk("wrap_addr0",  log_addr(0), 32'd11);
        chk("wrap_data0",  log_data(0), 32'h00AA_AAAA);
        chk("wrap_addr1",  log_addr(1), 32'd0);
        chk("wrap_data1",  log_data(1), 32'h00BB_BBBB);
        clear_log();
        send(32'h0000_00C8);
        send(32'h40CC_CCCC);
        send(32'hC000_0003);
        send(32'h4000_0011);
        wait_idle(50);
        chk("oor_count", 32'(q_addr.size()), 32'd2);
        chk("oor_addr",  log_addr(0), 32'd0);
        chk("oor_data",  log_data(0), 32'h00CC_CCCC);
        chk("rsv_addr",  log_addr(1), 32'd1);
        chk("rsv_data",  log_data(1), 32'h0000_0011);

        // Fill with ctrl_ready alternating; pointer must survive the fill
        send(32'h0000_0007);
        wait_idle(20);
        clear_log();
        bad_strobes = 0;
        send(32'h8012_3456);
        for (int i = 0; i < 60; i++) begin
            ctrl_ready = ((i % 2) == 0);
            tick();
        end
        ctrl_ready = 1'b1;
        wait_idle(10);
        chk("fill_count", 32'(q_addr.size()), 32'd12);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("fill_addr%0d", i), log_addr(i), 32'(i));
            chk($sformatf("fill_data%0d", i), log_data(i), 32'h0012_3456);
        end
        chk("fill_ready_low_strobes", 32'(bad_strobes), 32'd0);
        clear_log();
        send(32'h4000_0001);
        wait_idle(20);
        chk("fill_ptr_kept", log_addr(0), 32'd7);

        // Overflow: one command parks in the engine, four fill the FIFO, the sixth is dropped
        send(32'h0000_0000);
        wait_idle(20);
        clear_log();
        chk("ovf_before", 32'(overflow), 32'd0);
        ctrl_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            send(32'h4000_0000 | 32'(i));
        end
        chk("ovf_full", 32'(cmd_full), 32'd1);
        chk("ovf_flag", 32'(overflow), 32'd1);
        ctrl_ready = 1'b1;
        wait_idle(50);
        chk("ovf_count", 32'(q_addr.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("ovf_addr%0d", i), log_addr(i), 32'(i));
            chk($sformatf("ovf_data%0d", i), log_data(i), 32'(i + 1));
        end
        chk("ovf_sticky", 32'(overflow), 32'd1);
        chk("ovf_full_clear", 32'(cmd_full), 32'd0);

        // Reset in the middle of a fill
        clear_log();
        send(32'h80AB_CDEF);
        seen = 0;
        n    = 0;
        while (seen < 4 && n < 100) begin
            tick();
            n++;
            if (ctrl_write_en === 1'b1) seen++;
        end
        chk("mid_fill_seen", 32'(seen), 32'd4);
        @(negedge ctrl_clock);
        #1;
        ctrl_reset_n = 1'b0;
        #1;
        chk("mrst_wen",  32'(ctrl_write_en), 32'd0);
        chk("mrst_addr", ctrl_address,       32'd0);
        chk("mrst_data", ctrl_write_data,    32'd0);
        chk("mrst_full", 32'(cmd_full),      32'd0);
        chk("mrst_ovf",  32'(overflow),      32'd0);
        chk("mrst_busy", 32'(busy),          32'd0);
        cmd_data     = 32'h4000_0077;
        cmd_write_en = 1'b1;
        tick();
        tick();
        cmd_write_en = 1'b0;
        tick();
        ctrl_reset_n = 1'b1;
        chk("post_rst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 30; i++) tick();
        chk("post_rst_count", 32'(q_addr.size()), 32'd4);
        chk("mid_fill_addr3", log_addr(3), 32'd3);
        chk("mid_fill_data3", log_data(3), 32'h00AB_CDEF);
        send(32'h4000_0099);
        wait_idle(20);
        chk("post_rst_wcount", 32'(q_addr.size()), 32'd5);
        chk("post_rst_addr",   log_addr(4), 32'd0);
        chk("post_rst_data",   log_data(4), 32'h0000_0099);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
